// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic/add/shift ops finish 1 cycle after transfer, MUL/DIV/REM finish after WIDTH+1 cycles.
// One operation in flight at a time: in_ready only in IDLE, result held in DONE until out_ready.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] imm_val,
   input  logic             imm,
   input  logic [3:0]       func,
   input  logic             signed_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [7:0]       status_reg
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);

   localparam logic [3:0] F_NOP  = 4'b0000;
   localparam logic [3:0] F_ADD  = 4'b0001;
   localparam logic [3:0] F_SUB  = 4'b0010;
   localparam logic [3:0] F_MUL  = 4'b0011;
   localparam logic [3:0] F_AND  = 4'b0100;
   localparam logic [3:0] F_OR   = 4'b0101;
   localparam logic [3:0] F_XOR  = 4'b0110;
   localparam logic [3:0] F_XNOR = 4'b0111;
   localparam logic [3:0] F_SHL  = 4'b1000;
   localparam logic [3:0] F_SHR  = 4'b1001;
   localparam logic [3:0] F_SRA  = 4'b1010;
   localparam logic [3:0] F_DIV  = 4'b1011;
   localparam logic [3:0] F_REM  = 4'b1100;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] t;
      logic [WIDTH-1:0] b;
      logic [3:0]       func;
      logic             sgn;
   } op_t;

   state_t           state_q, state_d;
   op_t              op_q, cur;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic [WIDTH-1:0] quo_q, rem_q, dvsr_q;
   logic             neg_q;

   logic             fire, iter_op, load_res;
   logic             t_neg, b_neg;
   logic [WIDTH-1:0] t_mag, b_mag;
   logic [WIDTH-1:0] acc_nxt, quo_nxt, rem_nxt, rem_diff;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH-1:0] res_d;
   logic [7:0]       status_d;
   logic             carry, divz, gt, eq, big;
   logic [CW-1:0]    sh;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign fire      = in_valid & in_ready;

   // While idle the operands come straight from the ports; afterwards from the captured copy.
   always_comb begin
      cur = op_q;
      if (state_q == IDLE) begin
         cur.t    = imm ? imm_val : a;
         cur.b    = b;
         cur.func = func;
         cur.sgn  = signed_op;
      end
   end

   assign iter_op = (cur.func == F_MUL) || (cur.func == F_DIV) || (cur.func == F_REM);
   assign t_neg   = cur.sgn & cur.t[WIDTH-1];
   assign b_neg   = cur.sgn & cur.b[WIDTH-1];
   assign t_mag   = t_neg ? -cur.t : cur.t;
   assign b_mag   = b_neg ? -cur.b : cur.b;

   // One shift-add multiply step and one restoring-divide step per BUSY cycle.
   assign acc_nxt  = mplier_q[0] ? acc_q + mcand_q : acc_q;
   assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
   assign rem_ge   = rem_sh >= {1'b0, dvsr_q};
   assign rem_diff = rem_sh[WIDTH-1:0] - dvsr_q;
   assign rem_nxt  = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
   assign quo_nxt  = {quo_q[WIDTH-2:0], rem_ge};

   assign sh   = cur.b[CW-1:0];
   assign big  = cur.b >= WIDTH_V;
   assign divz = ((cur.func == F_DIV) || (cur.func == F_REM)) && (cur.b == '0);
   assign eq   = (cur.t == cur.b);
   assign gt   = cur.sgn ? ($signed(cur.t) > $signed(cur.b)) : (cur.t > cur.b);

   always_comb begin
      res_d = '0;
      carry = 1'b0;
      case (cur.func)
         F_NOP:  res_d = cur.t;
         F_ADD:  {carry, res_d} = {1'b0, cur.t} + {1'b0, cur.b};
         F_SUB: begin
            res_d = cur.t - cur.b;
            carry = cur.t < cur.b;
         end
         F_MUL:  res_d = neg_q ? -acc_nxt : acc_nxt;
         F_AND:  res_d = cur.t & cur.b;
         F_OR:   res_d = cur.t | cur.b;
         F_XOR:  res_d = cur.t ^ cur.b;
         F_XNOR: res_d = ~(cur.t ^ cur.b);
         F_SHL:  res_d = big ? '0 : cur.t << sh;
         F_SHR:  res_d = big ? '0 : cur.t >> sh;
         F_SRA:  res_d = big ? {WIDTH{cur.t[WIDTH-1]}} : WIDTH'($signed(cur.t) >>> sh);
         F_DIV:  res_d = divz ? '1 : (neg_q ? -quo_nxt : quo_nxt);
         F_REM:  res_d = divz ? cur.t : (neg_q ? -rem_nxt : rem_nxt);
         default: res_d = '0;
      endcase
   end

   assign status_d = {divz, carry, ~gt, ~gt & ~eq, gt | eq, gt, |res_d, ~|res_d};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fire) state_d = iter_op ? BUSY : DONE;
         BUSY:    if (cnt_q == '0) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign load_res = ((state_q == IDLE) && fire && !iter_op) ||
                     ((state_q == BUSY) && (cnt_q == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         neg_q      <= 1'b0;
         out        <= '0;
         status_reg <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && fire) begin
            op_q     <= cur;
            cnt_q    <= CNT_INIT;
            acc_q    <= '0;
            mcand_q  <= t_mag;
            mplier_q <= b_mag;
            quo_q    <= t_mag;
            rem_q    <= '0;
            dvsr_q   <= b_mag;
            // Remainder follows the dividend's sign; products and quotients follow the XOR.
            neg_q    <= (cur.func == F_REM) ? t_neg : (t_neg ^ b_neg);
         end
         if (state_q == BUSY) begin
            acc_q    <= acc_nxt;
            mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            quo_q    <= quo_nxt;
            rem_q    <= rem_nxt;
            cnt_q    <= cnt_q - 1'b1;
         end
         if (load_res) begin
            out        <= res_d;
            status_reg <= status_d;
         end
      end
   end

endmodule
